// File: rtl/tlc5957_pkg.sv
// Shared definitions for the TLC5957 serial receiver: LAT-width command
// counts, shift register width, GS word layout and decoded command actions.
package tlc5957_pkg;

    localparam int unsigned SR_WIDTH = 48;

    // Number of SCLK rising edges seen while LAT is high, per command
    localparam int unsigned CMD_WRTGS     = 1;
    localparam int unsigned CMD_LATGS     = 3;
    localparam int unsigned CMD_WRTFC     = 5;
    localparam int unsigned CMD_LINERESET = 7;
    localparam int unsigned CMD_READFC    = 11;
    localparam int unsigned CMD_FCWRTEN   = 15;

    // One GS entry: {B, G, R}, 16 bits each
    typedef logic [2:0][15:0] gs_word_t;

    // Action selected by a LAT falling edge
    typedef enum logic [2:0] {
        ACT_WRTGS,
        ACT_LATGS,
        ACT_WRTFC,
        ACT_LINERESET,
        ACT_READFC,
        ACT_FCWRTEN,
        ACT_ERR
    } cmd_e;

endpackage

// File: rtl/tlc5957_cmd_decode.sv
// LAT-width command classifier for the TLC5957 receiver.
// Maps the LAT-high SCLK edge count to a decoded action. A saturated count,
// zero, or any count without a command is reported as ACT_ERR.
// Optional macro: TLC5957_RX_READFC_EN enables the READFC command (count 11);
// without it, count 11 is classified as an error.
module tlc5957_cmd_decode
    import tlc5957_pkg::*;
#(
    parameter int unsigned LAT_CNT_WIDTH = 5
) (
    input  logic [LAT_CNT_WIDTH-1:0] lat_cnt_i,
    output cmd_e                     cmd_o
);

    // Classify the count; the saturated value never maps to a command
    always_comb begin
        cmd_o = ACT_ERR;
        if (lat_cnt_i != '1) begin
            case (lat_cnt_i)
                LAT_CNT_WIDTH'(CMD_WRTGS):     cmd_o = ACT_WRTGS;
                LAT_CNT_WIDTH'(CMD_LATGS):     cmd_o = ACT_LATGS;
                LAT_CNT_WIDTH'(CMD_WRTFC):     cmd_o = ACT_WRTFC;
                LAT_CNT_WIDTH'(CMD_LINERESET): cmd_o = ACT_LINERESET;
                LAT_CNT_WIDTH'(CMD_FCWRTEN):   cmd_o = ACT_FCWRTEN;
`ifdef TLC5957_RX_READFC_EN
                LAT_CNT_WIDTH'(CMD_READFC):    cmd_o = ACT_READFC;
`else
                LAT_CNT_WIDTH'(CMD_READFC):    cmd_o = ACT_ERR;
`endif
                default:                       cmd_o = ACT_ERR;
            endcase
        end
    end

endmodule

// File: rtl/tlc5957_rx.sv
// TLC5957 serial interface receiver, fully in the clk domain.
// Rebuilds the 48-bit common shift register from SCLK/SIN, decodes LAT-width
// commands on the LAT falling edge, and keeps GS latch 1, GS latch 2, the FC
// register and the FC write-enable flag.
// Optional macro: TLC5957_RX_READFC_EN enables READFC and the SOUT readback.
module tlc5957_rx
    import tlc5957_pkg::*;
#(
    parameter int unsigned          NB_LEDS_PER_GROUP = 16,
    parameter logic [SR_WIDTH-1:0]  FC_RESET          = 48'h0,
    parameter int unsigned          LAT_CNT_WIDTH     = 5,
    localparam int unsigned         IDX_W             = $clog2(NB_LEDS_PER_GROUP)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SCLK,
    input  logic                SIN,
    input  logic                LAT,
    input  logic [IDX_W-1:0]    rd_led,
    output logic [SR_WIDTH-1:0] rd_data,
    output logic [SR_WIDTH-1:0] fc_data,
    output logic                fcwrten,
    output logic [IDX_W-1:0]    gs_ptr,
    output logic                latgs_pulse,
    output logic                wrtfc_pulse,
    output logic                linereset_pulse,
    output logic                cmd_err,
    output logic                SOUT
);

    logic                     sclk_q;
    logic                     lat_q;
    logic                     sclk_rise;
    logic                     lat_fall;

    logic [SR_WIDTH-1:0]      shift_q,    shift_d;
    logic [LAT_CNT_WIDTH-1:0] lat_cnt_q,  lat_cnt_d;
    logic [IDX_W-1:0]         gs_ptr_q,   gs_ptr_d;
    logic [SR_WIDTH-1:0]      fc_q,       fc_d;
    logic                     fcwrten_q,  fcwrten_d;
    logic                     latgs_q,    latgs_d;
    logic                     wrtfc_q,    wrtfc_d;
    logic                     lreset_q,   lreset_d;
    logic                     err_q,      err_d;

    logic                     wr1_en;
    logic                     cp2_en;

    gs_word_t                 latch1_q [NB_LEDS_PER_GROUP];
    gs_word_t                 latch2_q [NB_LEDS_PER_GROUP];

    cmd_e                     cmd;

    assign sclk_rise = SCLK & ~sclk_q;
    assign lat_fall  = lat_q & ~LAT;

    tlc5957_cmd_decode #(
        .LAT_CNT_WIDTH(LAT_CNT_WIDTH)
    ) u_cmd_decode (
        .lat_cnt_i(lat_cnt_q),
        .cmd_o    (cmd)
    );

    // Next-state: serial shift, LAT edge counting and command actions.
    // Decode uses the pre-edge shift_q/lat_cnt_q; a READFC load takes
    // priority over a coincident SCLK shift.
    always_comb begin
        shift_d   = shift_q;
        lat_cnt_d = lat_cnt_q;
        gs_ptr_d  = gs_ptr_q;
        fc_d      = fc_q;
        fcwrten_d = fcwrten_q;
        latgs_d   = 1'b0;
        wrtfc_d   = 1'b0;
        lreset_d  = 1'b0;
        err_d     = 1'b0;
        wr1_en    = 1'b0;
        cp2_en    = 1'b0;

        if (sclk_rise) begin
            shift_d = {shift_q[SR_WIDTH-2:0], SIN};
        end

        if (lat_fall) begin
            lat_cnt_d = '0;
        end else if (sclk_rise && LAT && (lat_cnt_q != '1)) begin
            lat_cnt_d = lat_cnt_q + LAT_CNT_WIDTH'(1);
        end

        if (lat_fall) begin
            case (cmd)
                ACT_WRTGS: begin
                    wr1_en   = 1'b1;
                    gs_ptr_d = gs_ptr_q + IDX_W'(1);
                end
                ACT_LATGS, ACT_LINERESET: begin
                    wr1_en   = 1'b1;
                    cp2_en   = 1'b1;
                    gs_ptr_d = '0;
                    latgs_d  = 1'b1;
                    lreset_d = (cmd == ACT_LINERESET);
                end
                ACT_WRTFC: begin
                    if (fcwrten_q) begin
                        fc_d      = shift_q;
                        fcwrten_d = 1'b0;
                        wrtfc_d   = 1'b1;
                    end
                end
                ACT_FCWRTEN: begin
                    fcwrten_d = 1'b1;
                end
                ACT_READFC: begin
`ifdef TLC5957_RX_READFC_EN
                    shift_d = fc_q;
`endif
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Control and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            shift_q   <= '0;
            lat_cnt_q <= '0;
            gs_ptr_q  <= '0;
            fc_q      <= FC_RESET;
            fcwrten_q <= 1'b0;
            latgs_q   <= 1'b0;
            wrtfc_q   <= 1'b0;
            lreset_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sclk_q    <= SCLK;
            lat_q     <= LAT;
            shift_q   <= shift_d;
            lat_cnt_q <= lat_cnt_d;
            gs_ptr_q  <= gs_ptr_d;
            fc_q      <= fc_d;
            fcwrten_q <= fcwrten_d;
            latgs_q   <= latgs_d;
            wrtfc_q   <= wrtfc_d;
            lreset_q  <= lreset_d;
            err_q     <= err_d;
        end
    end

    // GS latches; latch 2 takes latch 1 with the entry being written merged in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NB_LEDS_PER_GROUP; i++) begin
                latch1_q[i] <= '0;
                latch2_q[i] <= '0;
            end
        end else begin
            if (wr1_en) begin
                latch1_q[gs_ptr_q] <= shift_q;
            end
            if (cp2_en) begin
                for (int unsigned i = 0; i < NB_LEDS_PER_GROUP; i++) begin
                    latch2_q[i] <= (IDX_W'(i) == gs_ptr_q) ? shift_q : latch1_q[i];
                end
            end
        end
    end

    assign rd_data         = latch2_q[rd_led];
    assign fc_data         = fc_q;
    assign fcwrten         = fcwrten_q;
    assign gs_ptr          = gs_ptr_q;
    assign latgs_pulse     = latgs_q;
    assign wrtfc_pulse     = wrtfc_q;
    assign linereset_pulse = lreset_q;
    assign cmd_err         = err_q;

`ifdef TLC5957_RX_READFC_EN
    assign SOUT = shift_q[SR_WIDTH-1];
`else
    assign SOUT = 1'b0;
`endif

endmodule

// File: tb/tb_tlc5957_rx.sv
// Self-checking bench for tlc5957_rx against a frame-level reference model.
module tb_tlc5957_rx;

    localparam int unsigned NB     = 16;
    localparam logic [47:0] FC_RST = 48'h0;
    localparam logic [47:0] FC_VAL = 48'h5c0201008048;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCLK;
    logic        SIN;
    logic        LAT;
    logic [3:0]  rd_led;
    logic [47:0] rd_data;
    logic [47:0] fc_data;
    logic        fcwrten;
    logic [3:0]  gs_ptr;
    logic        latgs_pulse;
    logic        wrtfc_pulse;
    logic        linereset_pulse;
    logic        cmd_err;
    logic        SOUT;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [47:0] m_l1 [NB];
    logic [47:0] m_l2 [NB];
    logic [47:0] m_fc;
    logic [47:0] m_sr;
    logic        m_fcw;
    int          m_ptr;
    logic [3:0]  m_pulses;   // {latgs, wrtfc, linereset, err}

    always #5 clk = ~clk;

    tlc5957_rx #(
        .NB_LEDS_PER_GROUP(NB),
        .FC_RESET         (FC_RST),
        .LAT_CNT_WIDTH    (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .SCLK           (SCLK),
        .SIN            (SIN),
        .LAT            (LAT),
        .rd_led         (rd_led),
        .rd_data        (rd_data),
        .fc_data        (fc_data),
        .fcwrten        (fcwrten),
        .gs_ptr         (gs_ptr),
        .latgs_pulse    (latgs_pulse),
        .wrtfc_pulse    (wrtfc_pulse),
        .linereset_pulse(linereset_pulse),
        .cmd_err        (cmd_err),
        .SOUT           (SOUT)
    );

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rand48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_l1[i] = '0;
            m_l2[i] = '0;
        end
        m_fc     = FC_RST;
        m_sr     = '0;
        m_fcw    = 1'b0;
        m_ptr    = 0;
        m_pulses = '0;
    endtask

    // Command semantics at frame level: cnt is the number of SCLK edges with LAT high
    task automatic model_cmd(input int cnt);
        int c;
        c = (cnt > 31) ? 31 : cnt;
        m_pulses = '0;
        case (c)
            1: begin
                m_l1[m_ptr] = m_sr;
                m_ptr = (m_ptr + 1) % NB;
            end
            3, 7: begin
                m_l1[m_ptr] = m_sr;
                m_l2 = m_l1;
                m_ptr = 0;
                m_pulses[3] = 1'b1;
                if (c == 7) m_pulses[1] = 1'b1;
            end
            5: begin
                if (m_fcw) begin
                    m_fc = m_sr;
                    m_fcw = 1'b0;
                    m_pulses[2] = 1'b1;
                end
            end
            15: m_fcw = 1'b1;
`ifdef TLC5957_RX_READFC_EN
            11: m_sr = m_fc;
`endif
            default: m_pulses[0] = 1'b1;
        endcase
    endtask

    // Shift a 48-bit frame MSB first with LAT high over the last cnt SCLK edges,
    // then drop LAT; returns one sample point after the decode edge.
    task automatic send_frame(input logic [47:0] w, input int cnt);
        if (cnt == 0) begin
            LAT = 1'b1;
            tick();
            tick();
        end else begin
            for (int i = 47; i >= 0; i--) begin
                SIN  = w[i];
                LAT  = (i < cnt);
                SCLK = 1'b0;
                tick();
                SCLK = 1'b1;
                tick();
            end
            SCLK = 1'b0;
            tick();
            m_sr = w;
        end
        LAT = 1'b0;
        tick();
        model_cmd(cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; SCLK = 1'b0; SIN = 1'b0; LAT = 1'b0; rd_led = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        for (int i = 0; i < NB; i++) begin
            rd_led = 4'(i);
            #1;
            n_total++;
            if (rd_data !== 48'h0) $display("FAIL reset_rd_data[%0d] got %h exp 0", i, rd_data);
            else n_pass++;
        end
        n_total++;
        if (fc_data !== FC_RST) $display("FAIL reset_fc got %h exp %h", fc_data, FC_RST);
        else n_pass++;
        n_total++;
        if ({fcwrten, gs_ptr, SOUT} !== 6'b0) $display("FAIL reset_ctrl got fcwrten=%b gs_ptr=%0d SOUT=%b exp 0", fcwrten, gs_ptr, SOUT);
        else n_pass++;
        n_total++;
        if ({latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err} !== 4'b0)
            $display("FAIL reset_pulses got %b exp 0000", {latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err});
        else n_pass++;
    endtask

    task automatic test_latgs();
        for (int n = 0; n < 15; n++) begin
            send_frame(48'h0001_0002_0003 + 48'(n), 1);
            n_total++;
            if ({latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err, gs_ptr} !== {m_pulses, 4'(m_ptr)})
                $display("FAIL wrtgs_%0d got pulses=%b gs_ptr=%0d exp pulses=%b gs_ptr=%0d", n,
                         {latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err}, gs_ptr, m_pulses, m_ptr);
            else n_pass++;
        end
        send_frame(48'hAAAA_BBBB_CCCC, 3);
        n_total++;
        if ({latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err} !== 4'b1000)
            $display("FAIL latgs_pulse got %b exp 1000", {latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err});
        else n_pass++;
        n_total++;
        if (gs_ptr !== 4'd0) $display("FAIL latgs_gs_ptr got %0d exp 0", gs_ptr);
        else n_pass++;
        for (int i = 0; i < NB; i++) begin
            rd_led = 4'(i);
            #1;
            n_total++;
            if (rd_data !== ((i == 15) ? 48'hAAAA_BBBB_CCCC : 48'h0001_0002_0003 + 48'(i)))
                $display("FAIL latgs_rd_data[%0d] got %h exp %h", i, rd_data, m_l2[i]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (latgs_pulse !== 1'b0) $display("FAIL latgs_pulse_width got %b exp 0", latgs_pulse);
        else n_pass++;
    endtask

    task automatic test_fc();
        send_frame(FC_VAL, 5);
        n_total++;
        if ({fc_data, fcwrten, wrtfc_pulse, cmd_err} !== {FC_RST, 3'b000})
            $display("FAIL wrtfc_locked got fc=%h en=%b pulse=%b err=%b exp fc=%h 0 0 0", fc_data, fcwrten, wrtfc_pulse, cmd_err, FC_RST);
        else n_pass++;
        send_frame(rand48(), 15);
        n_total++;
        if ({fcwrten, cmd_err} !== 2'b10) $display("FAIL fcwrten_set got en=%b err=%b exp 1 0", fcwrten, cmd_err);
        else n_pass++;
        send_frame(FC_VAL, 5);
        n_total++;
        if ({fc_data, fcwrten, wrtfc_pulse} !== {FC_VAL, 2'b01})
            $display("FAIL wrtfc got fc=%h en=%b pulse=%b exp fc=%h 0 1", fc_data, fcwrten, wrtfc_pulse, FC_VAL);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [47:0] w17;
        logic [47:0] wl;
        for (int n = 0; n < 17; n++) begin
            w17 = rand48();
            send_frame(w17, 1);
        end
        n_total++;
        if (gs_ptr !== 4'd1) $display("FAIL wrap_gs_ptr got %0d exp 1", gs_ptr);
        else n_pass++;
        wl = rand48();
        send_frame(wl, 3);
        rd_led = 4'd0;
        #1;
        n_total++;
        if (rd_data !== w17) $display("FAIL wrap_entry0 got %h exp %h", rd_data, w17);
        else n_pass++;
        rd_led = 4'd1;
        #1;
        n_total++;
        if (rd_data !== wl) $display("FAIL wrap_entry1 got %h exp %h", rd_data, wl);
        else n_pass++;
        n_total++;
        if (gs_ptr !== 4'd0) $display("FAIL wrap_latgs_ptr got %0d exp 0", gs_ptr);
        else n_pass++;
    endtask

    task automatic test_errors();
        int cnts [4] = '{2, 4, 0, 40};
        send_frame(rand48(), 1);    // leave gs_ptr non-zero
        foreach (cnts[k]) begin
            send_frame(rand48(), cnts[k]);
            n_total++;
            if ({latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err} !== 4'b0001)
                $display("FAIL err_cnt%0d_pulse got %b exp 0001", cnts[k], {latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err});
            else n_pass++;
            n_total++;
            if ({gs_ptr, fc_data, fcwrten} !== {4'(m_ptr), m_fc, m_fcw})
                $display("FAIL err_cnt%0d_state got ptr=%0d fc=%h en=%b exp ptr=%0d fc=%h en=%b",
                         cnts[k], gs_ptr, fc_data, fcwrten, m_ptr, m_fc, m_fcw);
            else n_pass++;
        end
        for (int i = 0; i < NB; i++) begin
            rd_led = 4'(i);
            #1;
            n_total++;
            if (rd_data !== m_l2[i]) $display("FAIL err_latch2[%0d] got %h exp %h", i, rd_data, m_l2[i]);
            else n_pass++;
        end
    endtask

    task automatic test_readfc();
        logic [47:0] exp_fc;
        logic [47:0] rb;
        exp_fc = m_fc;
        send_frame(rand48(), 11);
`ifdef TLC5957_RX_READFC_EN
        n_total++;
        if ({latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err} !== 4'b0)
            $display("FAIL readfc_pulses got %b exp 0000", {latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err});
        else n_pass++;
        rb = rand48();
        for (int i = 47; i >= 0; i--) begin
            n_total++;
            if (SOUT !== exp_fc[i]) $display("FAIL readfc_sout_bit%0d got %b exp %b", i, SOUT, exp_fc[i]);
            else n_pass++;
            SIN  = rb[i];
            SCLK = 1'b1;
            tick();
            SCLK = 1'b0;
            tick();
        end
        m_sr = rb;
`else
        n_total++;
        if ({cmd_err, SOUT} !== 2'b10) $display("FAIL readfc_disabled got err=%b sout=%b exp 1 0", cmd_err, SOUT);
        else n_pass++;
`endif
        n_total++;
        if (fc_data !== exp_fc) $display("FAIL readfc_fc got %h exp %h", fc_data, exp_fc);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        for (int i = 23; i >= 0; i--) begin
            SIN  = 1'($urandom());
            LAT  = (i < 5);
            SCLK = 1'b0;
            tick();
            SCLK = 1'b1;
            tick();
        end
        rst = 1'b1; SCLK = 1'b0; LAT = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        send_frame(rand48(), 3);
        n_total++;
        if ({latgs_pulse, cmd_err, gs_ptr, fc_data} !== {2'b10, 4'd0, FC_RST})
            $display("FAIL midreset got latgs=%b err=%b ptr=%0d fc=%h exp 1 0 0 %h", latgs_pulse, cmd_err, gs_ptr, fc_data, FC_RST);
        else n_pass++;
        rd_led = 4'd0;
        #1;
        n_total++;
        if (rd_data !== m_l2[0]) $display("FAIL midreset_entry0 got %h exp %h", rd_data, m_l2[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int pool [13] = '{1, 1, 1, 3, 5, 7, 15, 15, 2, 0, 11, 20, 40};
        int c;
        for (int n = 0; n < 40; n++) begin
            c = pool[$urandom_range(12)];
            send_frame(rand48(), c);
            n_total++;
            if ({latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err, gs_ptr, fc_data, fcwrten} !==
                {m_pulses, 4'(m_ptr), m_fc, m_fcw})
                $display("FAIL rand_%0d_cnt%0d got p=%b ptr=%0d fc=%h en=%b exp p=%b ptr=%0d fc=%h en=%b", n, c,
                         {latgs_pulse, wrtfc_pulse, linereset_pulse, cmd_err}, gs_ptr, fc_data, fcwrten,
                         m_pulses, m_ptr, m_fc, m_fcw);
            else n_pass++;
            rd_led = 4'($urandom_range(NB - 1));
            #1;
            n_total++;
            if (rd_data !== m_l2[rd_led]) $display("FAIL rand_%0d_rd[%0d] got %h exp %h", n, rd_led, rd_data, m_l2[rd_led]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latgs();
        test_fc();
        test_wrap();
        test_errors();
        test_readfc();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tlc5957_rx.md
Name: tlc5957_rx

Overview:
Synthesizable receiver for the TLC5957 serial interface (SCLK/SIN/LAT) driven by the led band controller. It runs entirely in the clk domain. It reconstructs the 48-bit common shift register, decodes LAT-width commands, and maintains the GS data latch 1, GS data latch 2, the FC register and the FC write-enable flag. It is used as an on-chip loopback checker and as a bench scoreboard source for the led band path.

Parameters:
NB_LEDS_PER_GROUP, 16, number of 48-bit GS entries per latch; must be a power of two.
FC_RESET, 48'h0, reset value of the FC register.
LAT_CNT_WIDTH, 5, width of the LAT-high SCLK edge counter; saturates at all-ones.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
SCLK  in  1  serial clock level, synchronous to clk
SIN  in  1  serial data, MSB first, sampled on SCLK rising edge
LAT  in  1  latch/command line, synchronous to clk
rd_led  in  $clog2(NB_LEDS_PER_GROUP)  GS latch 2 read index
rd_data  out  48  GS latch 2 entry at rd_led {B,G,R} 16 bits each; combinational read
fc_data  out  48  current FC register
fcwrten  out  1  FC write-enable flag
gs_ptr  out  $clog2(NB_LEDS_PER_GROUP)  next latch 1 write index
latgs_pulse  out  1  one-clk pulse when latch 2 is updated
wrtfc_pulse  out  1  one-clk pulse when FC is written
linereset_pulse  out  1  one-clk pulse on LINERESET
cmd_err  out  1  one-clk pulse on an unsupported or empty LAT command
SOUT  out  1  serial readback; see Optional Feature

Behaviour:
- Reset (async, rst=1): shift_reg, both latches, gs_ptr, lat_cnt, all pulses, fcwrten and SOUT are 0; fc_data = FC_RESET. Reset asserted mid-frame discards the partial shift and the partial command.
- The module registers SCLK and LAT once (sclk_q, lat_q). SCLK rising edge = SCLK & ~sclk_q.
- On each SCLK rising edge: shift_reg <= {shift_reg[46:0], SIN}. If LAT=1 on that clk, lat_cnt increments, saturating.
- Command decode fires on the LAT falling edge (lat_q & ~LAT). It uses lat_cnt and shift_reg as registered before that clk. lat_cnt clears in the same clk. Decoded actions are registered, so pulses appear 1 clk after the LAT fall.
  - 1 = WRTGS: latch1[gs_ptr] <= shift_reg; gs_ptr++, wrapping from NB_LEDS_PER_GROUP-1 to 0 (the entry is overwritten, no error).
  - 3 = LATGS: latch1[gs_ptr] <= shift_reg; latch2 <= latch1 including the new entry in the same clk; gs_ptr <= 0; latgs_pulse. The copy happens regardless of gs_ptr alignment.
  - 5 = WRTFC: if fcwrten=1, fc_data <= shift_reg, fcwrten <= 0, wrtfc_pulse. If fcwrten=0, the command is ignored with no error.
  - 7 = LINERESET: same actions as LATGS, plus linereset_pulse.
  - 15 = FCWRTEN: fcwrten <= 1.
  - 11 = READFC: see Optional Feature.
  - Any other count, including 0 and saturated: cmd_err pulse, no state change.
- SCLK rising edge and LAT falling edge in the same clk: the shift happens, lat_cnt does not increment (LAT low), and decode uses the pre-shift shift_reg.
- LAT rising while the previous command is still pending cannot occur; decode completes in 1 clk.
- rd_data is a combinational read of latch2[rd_led].

Optional Feature:
- Macro TLC5957_RX_READFC_EN.
- Defined: SOUT = shift_reg[47]. A count of 11 loads shift_reg <= fc_data so the FC register can be shifted back out.
- Undefined: SOUT is constant 0. A count of 11 raises cmd_err.

Decomposition:
- Package tlc5957_pkg holds:
  - localparams for the command counts CMD_WRTGS=1, CMD_LATGS=3, CMD_WRTFC=5, CMD_LINERESET=7, CMD_READFC=11, CMD_FCWRTEN=15;
  - SR_WIDTH=48;
  - typedef gs_word_t as logic [2:0][15:0];
  - typedef cmd_e enum of the decoded actions.
- One sub-module, tlc5957_cmd_decode: combinational lat_cnt -> cmd_e, including the cmd_err classification and macro handling.

Test Plan:
- Reset then idle 20 clk -> rd_data=0 for every index, fc_data=FC_RESET, fcwrten=0, all pulses 0.
- Shift 15 words 48'h0001_0002_0003 + n, each with WRTGS, then a 16th word 48'hAAAA_BBBB_CCCC with LATGS -> latgs_pulse 1 clk after the LAT fall; rd_led=n returns the n-th word; rd_led=15 returns AAAA_BBBB_CCCC; gs_ptr=0.
- WRTFC with 48'h5c0201008048 and fcwrten=0 -> fc_data unchanged, no pulse. Then FCWRTEN followed by WRTFC -> fc_data=48'h5c0201008048, wrtfc_pulse, fcwrten back to 0.
- 17 consecutive WRTGS -> gs_ptr=1; latch1[0] holds the 17th word. After LATGS, latch2[0] holds the 17th word.
- LAT held for 2, 4, 0 and 40 SCLK edges -> cmd_err pulse each time; latches, FC and gs_ptr unchanged.
- Macro defined: after FC = 48'h5c0201008048, READFC then 48 SCLK edges -> SOUT serialises 5c0201008048 MSB first. Macro undefined: READFC -> cmd_err, SOUT=0.
